// File: rtl/mdu_hilo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mdu_hilo : iterative multiply/divide unit owning the HI/LO pair.         |
// | Divider built only when MDU_DIV_EN is defined.  Revision 1.0             |
// +--------------------------------------------------------------------------+
module mdu_hilo #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int         c_CNT_W    = $clog2(WIDTH);
   localparam logic [1:0] c_IDLE     = 2'd0;
   localparam logic [1:0] c_RUN      = 2'd1;
   localparam logic [1:0] c_FIX      = 2'd2;
   localparam logic [2:0] c_OP_MULT  = 3'd0;
   localparam logic [2:0] c_OP_MULTU = 3'd1;
   localparam logic [2:0] c_OP_MTHI  = 3'd4;
   localparam logic [2:0] c_OP_MTLO  = 3'd5;

   logic [1:0]         r_state, w_next_state;
   logic [c_CNT_W-1:0] r_cnt;
   logic [2*WIDTH-1:0] r_acc;
   logic [WIDTH-1:0]   r_opnd;
   logic               r_neg;
   logic [WIDTH-1:0]   r_hi, r_lo;
   logic               r_done;

   logic               w_idle, w_is_mul, w_is_div, w_iter_go, w_mthi, w_mtlo;
   logic               w_signed, w_neg;
   logic [WIDTH-1:0]   w_abs_a, w_abs_b;
   logic [WIDTH:0]     w_madd;
   logic [2*WIDTH-1:0] w_mul_next, w_step, w_prod;
   logic [WIDTH-1:0]   w_res_hi, w_res_lo;

   assign w_idle    = (r_state == c_IDLE);
   assign w_is_mul  = (op == c_OP_MULT) || (op == c_OP_MULTU);
   assign w_iter_go = start && w_idle && (w_is_mul || w_is_div);
   assign w_mthi    = start && w_idle && (op == c_OP_MTHI);
   assign w_mtlo    = start && w_idle && (op == c_OP_MTLO);

   // Signed iterative ops (MULT, DIV) are the even op codes.
   assign w_signed = ~op[0];
   assign w_abs_a  = (w_signed && a[WIDTH-1]) ? -a : a;
   assign w_abs_b  = (w_signed && b[WIDTH-1]) ? -b : b;
   assign w_neg    = w_signed && (a[WIDTH-1] ^ b[WIDTH-1]);

   // Shift-add: upper half accumulates, multiplier drains from the bottom.
   assign w_madd     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
   assign w_mul_next = {w_madd, r_acc[WIDTH-1:1]};
   assign w_prod     = r_neg ? -r_acc : r_acc;

`ifdef MDU_DIV_EN
   localparam logic [2:0] c_OP_DIV  = 3'd2;
   localparam logic [2:0] c_OP_DIVU = 3'd3;

   logic               r_is_div, r_rem_neg, r_dz, r_div_zero;
   logic [WIDTH:0]     w_trial;
   logic [2*WIDTH-1:0] w_div_next;
   logic [WIDTH-1:0]   w_rem, w_quo;

   assign w_is_div = (op == c_OP_DIV) || (op == c_OP_DIVU);

   // Restoring step: remainder in the upper half, quotient shifts in at bit 0.
   assign w_trial    = r_acc[2*WIDTH-1:WIDTH-1] - {1'b0, r_opnd};
   assign w_div_next = w_trial[WIDTH] ? {r_acc[2*WIDTH-2:0], 1'b0}
                                      : {w_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
   assign w_step     = r_is_div ? w_div_next : w_mul_next;
   assign w_rem      = r_acc[2*WIDTH-1:WIDTH];
   assign w_quo      = r_acc[WIDTH-1:0];
   assign w_res_hi   = r_is_div ? (r_rem_neg ? -w_rem : w_rem) : w_prod[2*WIDTH-1:WIDTH];
   assign w_res_lo   = r_is_div ? (r_dz ? '1 : (r_neg ? -w_quo : w_quo))
                                : w_prod[WIDTH-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_is_div   <= 1'b0;
         r_rem_neg  <= 1'b0;
         r_dz       <= 1'b0;
         r_div_zero <= 1'b0;
      end else begin
         if (w_iter_go) begin
            r_is_div  <= w_is_div;
            r_rem_neg <= w_signed && a[WIDTH-1];
            r_dz      <= (b == '0);
         end
         if (w_iter_go || w_mthi || w_mtlo)
            r_div_zero <= 1'b0;
         else if (r_state == c_FIX && r_is_div)
            r_div_zero <= r_dz;
      end
   end
`else
   logic r_div_zero;

   assign w_is_div   = 1'b0;
   assign w_step     = w_mul_next;
   assign w_res_hi   = w_prod[2*WIDTH-1:WIDTH];
   assign w_res_lo   = w_prod[WIDTH-1:0];
   assign r_div_zero = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_state <= c_IDLE;
      else
         r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         c_IDLE:  if (w_iter_go) w_next_state = c_RUN;
         c_RUN:   if (r_cnt == '0) w_next_state = c_FIX;
         c_FIX:   w_next_state = c_IDLE;
         default: w_next_state = c_IDLE;
      endcase
   end

   always_comb begin
      busy     = (r_state != c_IDLE);
      done     = r_done;
      div_zero = r_div_zero;
      hi       = r_hi;
      lo       = r_lo;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt  <= '0;
         r_acc  <= '0;
         r_opnd <= '0;
         r_neg  <= 1'b0;
      end else if (w_iter_go) begin
         r_cnt <= c_CNT_W'(WIDTH - 1);
         r_neg <= w_neg;
         if (w_is_div) begin
            r_acc  <= {{WIDTH{1'b0}}, w_abs_a};
            r_opnd <= w_abs_b;
         end else begin
            r_acc  <= {{WIDTH{1'b0}}, w_abs_b};
            r_opnd <= w_abs_a;
         end
      end else if (r_state == c_RUN) begin
         r_cnt <= r_cnt - c_CNT_W'(1);
         r_acc <= w_step;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hi   <= '0;
         r_lo   <= '0;
         r_done <= 1'b0;
      end else begin
         r_done <= (r_state == c_FIX);
         if (r_state == c_FIX) begin
            r_hi <= w_res_hi;
            r_lo <= w_res_lo;
         end else if (w_mthi) begin
            r_hi <= a;
         end else if (w_mtlo) begin
            r_lo <= a;
         end
      end
   end

endmodule
`default_nettype wire

// File: doc/mdu_hilo.md
# mdu_hilo

Iterative multiply/divide unit that owns the HI/LO register pair. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO requests from the execute stage over a start/busy handshake and computes products and quotients over multiple cycles. It exposes HI/LO to the ALU result mux, which serves MFHI/MFLO. While it is busy, the pipeline stalls any MFHI/MFLO or new multiply/divide.

## Interface
- `WIDTH`, 32: operand width; HI and LO are each `WIDTH` bits.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset; one clock; reset is asynchronous and active-low.
- `start`  in  1  request valid; sampled only when `busy`=0.
- `op`  in  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO, 6–7 reserved (ignored).
- `a`  in  WIDTH  rs operand (multiplicand/dividend; MTHI/MTLO source).
- `b`  in  WIDTH  rt operand (multiplier/divisor).
- `busy`  out  1  iterative operation in progress; stall request to hazard unit.
- `done`  out  1  one-cycle pulse; HI/LO updated on the preceding edge.
- `div_zero`  out  1  sticky until next accepted start; last divide had `b`=0.
- `hi`  out  WIDTH  HI register.
- `lo`  out  WIDTH  LO register.

## Operation
- **FSM states.**
  - IDLE: `start`=1 with op 0–3 loads operands and goes to RUN.
  - RUN: 32 iterations, counter counts 31→0; at count 0 goes to FIX.
  - FIX: sign correction, HI/LO write, `done`=1 next cycle, then IDLE.
- **MTHI/MTLO.** Accepted in IDLE only. Writes HI (resp. LO) with `a` on the same edge. No `busy`, no `done`.
- **Multiply.** Shift-add over operand magnitudes, producing a 2·WIDTH product.
  - MULT takes |a|·|b| and negates the product when a[31]^b[31].
  - HI={product[63:32]}, LO=product[31:0].
  - MULTU treats operands as unsigned.
- **Divide.** Restoring division over magnitudes.
  - LO=quotient, HI=remainder.
  - Signed: quotient is negated if signs differ; remainder takes the dividend's sign (truncating division).
- **Boundary cases.**
  - Divide by zero (DIV/DIVU, `b`=0): HI=`a`, LO=32'hFFFF_FFFF, `div_zero`=1. Latency is the same as a normal divide.
  - DIV 32'h8000_0000 / 32'hFFFF_FFFF: LO=32'h8000_0000, HI=0; no flag.
  - MULT 32'h8000_0000 × 32'h8000_0000: HI=32'h4000_0000, LO=0.
- **Simultaneous events and reset.**
  - `start` while `busy`=1 is ignored, including MTHI/MTLO. HI/LO hold their old values until the FIX write.
  - Operands are latched at acceptance; later changes on `a`/`b` have no effect.
  - Reserved op codes leave all state unchanged.
  - Reset mid-operation aborts immediately to IDLE. Reset values: `hi`=0, `lo`=0, `busy`=0, `done`=0, `div_zero`=0.

## Timing
- **Acceptance.** Accept edge E0.
- **Busy window.** `busy`=1 from after E0 through E33 inclusive, i.e. 33 cycles. RUN spans edges E1–E32; FIX is written at E33.
- **Result.** `hi`/`lo` change at E33. `done`=1 for the cycle after E33. `busy` is 0 in that same cycle, so a new `start` may be accepted at E34.
- **Back-to-back.** Minimum issue interval between iterative ops is 34 cycles.
- **MTHI/MTLO.** Visible on `hi`/`lo` the cycle after the accept edge. A following MFHI/MFLO reads the new value with no stall.
- **Outputs.** `hi`, `lo`, `busy`, `done`, `div_zero` are registered outputs; none is combinational from inputs.

## Configuration
- **Macro:** `MDU_DIV_EN`.
- **Defined:** DIV/DIVU are implemented as above.
- **Undefined:**
  - Divider datapath is removed.
  - op 2/3 behave like reserved codes: no state change, no `busy`, no `done`.
  - `div_zero` is tied to 0.
  - MULT/MULTU/MTHI/MTLO are unchanged.

## Test plan
- **Reset.** Drive `rst_n`=0 mid-RUN of a MULT → `busy`=0, `done`=0, `hi`=`lo`=0 without waiting for a clock edge. After release, the next MTLO 32'h1234 gives `lo`=32'h1234.
- **Signed multiply.** MULT `a`=32'hFFFF_FFFE (−2), `b`=3 → `busy` for 33 cycles, `done` pulse, HI=32'hFFFF_FFFF, LO=32'hFFFF_FFFA.
- **Unsigned multiply.** MULTU `a`=`b`=32'hFFFF_FFFF → HI=32'hFFFF_FFFE, LO=32'h0000_0001. Hold `start`=1 with `op`=MTHI throughout → HI is unaffected until after `done`.
- **Signed divide.** DIV `a`=−7, `b`=2 → LO=32'hFFFF_FFFD (−3), HI=32'hFFFF_FFFF (−1).
- **Unsigned divide.** DIVU `a`=100, `b`=7 → LO=14, HI=2.
- **Divide by zero.** DIVU `a`=5, `b`=0 → HI=5, LO=32'hFFFF_FFFF, `div_zero`=1. The flag clears on the next accepted start.
- **Macro off.** With `MDU_DIV_EN` undefined, DIV leaves HI/LO unchanged and `busy` stays 0.
